// File: rtl/tick_sched_pkg.sv
// Shared types and defaults for the tick scheduler.
// Channel config struct and default sizing constants.
package tick_sched_pkg;

    localparam int N_CH_DEF  = 4;
    localparam int PER_W_DEF = 8;
    localparam int CH_W      = $clog2(N_CH_DEF);

    // Stored period is held at a fixed maximum width and
    // zero-extended from the PER_W-wide configuration port.
    localparam int PMAX = 16;

    typedef logic [PMAX-1:0] period_t;

    typedef struct packed {
        period_t period;
        logic    oneshot;
        logic    en;
    } ch_cfg_t;

    // Round-robin helper: channel index offset from a base, modulo n.
    function automatic int rr_idx(input int base, input int off, input int n);
        int v;
        v = base + off;
        if (v >= n) v = v - n;
        return v;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Base-tick prescaler: divides clk by BASE_DIV while run is high.
// Count is held (not cleared) while run is low.
module tick_prescaler #(
    parameter int BASE_DIV = 5000000
) (
    input  logic clk,
    input  logic rstn,
    input  logic run,
    output logic base_tick
);

    localparam int PW = (BASE_DIV > 2) ? $clog2(BASE_DIV) : 1;

    logic [PW-1:0] r_pcnt;
    logic          w_wrap;

    assign w_wrap    = (r_pcnt == PW'(BASE_DIV - 1));
    assign base_tick = run && w_wrap;

    // Advance the divider only while running; wrap at the terminal count.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pcnt <= '0;
        end else if (run) begin
            if (w_wrap) r_pcnt <= '0;
            else        r_pcnt <= r_pcnt + 1'b1;
        end
    end

endmodule

// File: rtl/tick_scheduler.sv
// Programmable game-tick scheduler: channels, pending flags, round-robin event port.
// Optional feature macro: TICK_SCHED_OVERRUN_EN adds sticky per-channel ovr flags.
module tick_scheduler
    import tick_sched_pkg::*;
#(
    parameter int BASE_DIV = 5000000,
    parameter int N_CH     = N_CH_DEF,
    parameter int PER_W    = PER_W_DEF
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    run,
    input  logic                    cfg_we,
    input  logic [$clog2(N_CH)-1:0] cfg_ch,
    input  logic [PER_W-1:0]        cfg_period,
    input  logic                    cfg_oneshot,
    input  logic                    cfg_en,
    output logic                    evt_valid,
    output logic [$clog2(N_CH)-1:0] evt_ch,
    input  logic                    evt_ready,
    output logic                    base_tick,
    output logic [N_CH-1:0]         pend
`ifdef TICK_SCHED_OVERRUN_EN
   ,output logic [N_CH-1:0]         ovr
`endif
);

    localparam int CW = $clog2(N_CH);

    ch_cfg_t          r_cfg [N_CH];
    logic [PER_W-1:0] r_cnt [N_CH];
    logic [N_CH-1:0]  r_pend;
    logic [CW-1:0]    r_last;
    logic             r_valid;
    logic [CW-1:0]    r_ch;

    logic             w_tick;
    logic [N_CH-1:0]  w_hit;
    logic [N_CH-1:0]  w_run;
    logic [N_CH-1:0]  w_exp;
    logic             w_load;
    logic             w_found;
    logic [CW-1:0]    w_pick;
    logic [N_CH-1:0]  w_grant;

    tick_prescaler #(
        .BASE_DIV (BASE_DIV)
    ) u_pre (
        .clk       (clk),
        .rstn      (rstn),
        .run       (run),
        .base_tick (w_tick)
    );

    assign base_tick = w_tick;
    assign evt_valid = r_valid;
    assign evt_ch    = r_ch;
    assign pend      = r_pend;

    // Per-channel decode: config hit, counting, and expiry this cycle.
    // A config write to a channel masks its tick for that cycle.
    always_comb begin
        w_hit = '0;
        w_run = '0;
        w_exp = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_hit[i] = cfg_we && (cfg_ch == CW'(i));
            w_run[i] = w_tick && !w_hit[i] && r_cfg[i].en
                       && (r_cfg[i].period != '0);
            w_exp[i] = w_run[i]
                       && (PMAX'(r_cnt[i]) == r_cfg[i].period - PMAX'(1));
        end
    end

    // Round-robin search starting one past the last granted channel.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_last;
        for (int k = 1; k <= N_CH; k++) begin
            int idx;
            idx = rr_idx(int'(r_last), k, N_CH);
            if (!w_found && r_pend[idx]) begin
                w_found = 1'b1;
                w_pick  = CW'(idx);
            end
        end
    end

    assign w_load  = (!r_valid || evt_ready) && (r_pend != '0);
    assign w_grant = w_load ? (N_CH'(1) << w_pick) : '0;

    // Channel config and counters; writes restart the count.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < N_CH; i++) begin
                r_cfg[i] <= '0;
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (w_hit[i]) begin
                    r_cfg[i].period  <= PMAX'(cfg_period);
                    r_cfg[i].oneshot <= cfg_oneshot;
                    r_cfg[i].en      <= cfg_en;
                    r_cnt[i]         <= '0;
                end else if (w_exp[i]) begin
                    r_cnt[i] <= '0;
                    if (r_cfg[i].oneshot) r_cfg[i].en <= 1'b0;
                end else if (w_run[i]) begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Pending flags: a new expiry wins over a same-cycle grant.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_pend <= '0;
        else       r_pend <= (r_pend & ~w_grant) | w_exp;
    end

    // Output slot and arbiter pointer.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_valid <= 1'b0;
            r_ch    <= '0;
            r_last  <= '0;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_ch    <= w_pick;
            r_last  <= w_pick;
        end else if (evt_ready) begin
            r_valid <= 1'b0;
        end
    end

`ifdef TICK_SCHED_OVERRUN_EN
    logic [N_CH-1:0] r_ovr;

    assign ovr = r_ovr;

    // Sticky overrun: expiry while an earlier event still waits.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_ovr <= '0;
        else       r_ovr <= (r_ovr & ~w_hit) | (w_exp & r_pend & ~w_grant);
    end
`endif

endmodule
